// File: rtl/wb_bram_loader.sv
// wb_bram_loader: packs a byte stream into big-endian words and writes them over Wishbone
module wb_bram_loader #(
  parameter logic [31:0] base_adr   = 32'h0000_0000,
  parameter int unsigned word_count = 512
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] words_o,
  output logic [31:0] sum_o
);
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q;
  logic [31:0] dat_q, adr_q, words_q, sum_q;
  logic cyc_q, rdy_q, busy_q, done_q;
  logic active, go, take, hit, last;
  always_comb begin
    active  = state_q inside {COLLECT, WRITE, GAP};
    go      = start_i && !abort_i && (state_q == IDLE || state_q == DONE);
    take    = !abort_i && state_q == COLLECT && rx_valid_i;
    hit     = !abort_i && state_q == WRITE && wb_ack_i;
    last    = words_q + 32'd1 == word_count;
    state_d = abort_i && active ? IDLE :
              go ? COLLECT :
              take && cnt_q == 2'd3 ? WRITE :
              hit ? (last ? DONE : GAP) :
              state_q == GAP ? COLLECT : state_q;
  end
  // outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dat_q   <= '0;
      adr_q   <= '0;
      words_q <= '0;
      sum_q   <= '0;
      cyc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= state_d == WRITE;
      rdy_q   <= state_d == COLLECT;
      busy_q  <= state_d inside {COLLECT, WRITE, GAP};
      done_q  <= state_d == DONE;
      if (go) begin
        adr_q   <= {base_adr[31:2], 2'b00};
        words_q <= '0;
        sum_q   <= '0;
        cnt_q   <= '0;
      end
      if (abort_i && active) cnt_q <= '0;
      if (take) begin
        dat_q <= {dat_q[23:0], rx_data_i};
        cnt_q <= cnt_q + 2'd1;
      end
      if (hit) begin
        sum_q   <= sum_q + dat_q;
        words_q <= words_q + 32'd1;
        adr_q   <= adr_q + 32'd4;
      end
    end
  end
  assign rx_ready_o = rdy_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = cyc_q;
  assign wb_sel_o   = {4{cyc_q}};
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign words_o    = words_q;
  assign sum_o      = sum_q;
endmodule
